// File: rtl/frame_serializer_if.sv
// frame_serializer_if: capture handshake from the Mixer stage plus valid/ready pixel stream
interface frame_serializer_if #(
  parameter int IMAGE_BITS = 8,
  parameter int MATRIX_N   = 120,
  parameter int MATRIX_M   = 120,
  parameter int COL_BITS   = 7,
  parameter int ROW_BITS   = 7,
  parameter int FLAT_WIDE  = IMAGE_BITS*MATRIX_N*MATRIX_M
);
  logic                  ReqIn;
  logic [FLAT_WIDE-1:0]  MatIn;
  logic                  AckIn;
  logic [IMAGE_BITS-1:0] PixOut;
  logic                  PixValid;
  logic                  PixReady;
  logic [ROW_BITS-1:0]   PixRow;
  logic [COL_BITS-1:0]   PixCol;
  logic                  FrameStart;
  logic                  FrameEnd;
  logic                  Busy;
  modport master (
    output ReqIn, MatIn, PixReady,
    input  AckIn, PixOut, PixValid, PixRow, PixCol, FrameStart, FrameEnd, Busy
  );
  modport slave (
    input  ReqIn, MatIn, PixReady,
    output AckIn, PixOut, PixValid, PixRow, PixCol, FrameStart, FrameEnd, Busy
  );
endinterface

// File: rtl/frame_serializer.sv
// frame_serializer: latches a flattened image matrix on request and streams it row-major one pixel per beat
module frame_serializer #(
  parameter int IMAGE_BITS = 8,
  parameter int MATRIX_N   = 120,
  parameter int MATRIX_M   = 120,
  parameter int COL_BITS   = 7,
  parameter int ROW_BITS   = 7,
  parameter int FLAT_WIDE  = IMAGE_BITS*MATRIX_N*MATRIX_M
) (
  input logic Clk,
  input logic Reset,
  frame_serializer_if.slave bus
);
  localparam int IDX_BITS = (FLAT_WIDE > 1) ? $clog2(FLAT_WIDE) : 1;
  localparam logic [COL_BITS-1:0] COL_LAST = COL_BITS'(MATRIX_N-1);
  localparam logic [ROW_BITS-1:0] ROW_LAST = ROW_BITS'(MATRIX_M-1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                state_q, state_d;
  logic                  armed_q, armed_d;
  logic [FLAT_WIDE-1:0]  buf_q, buf_d;
  logic [ROW_BITS-1:0]   row_q, row_d, row_n;
  logic [COL_BITS-1:0]   col_q, col_d, col_n;
  logic [IMAGE_BITS-1:0] pix_q, pix_d;
  logic                  ack_q, ack_d;
  logic                  capture, xfer, last_col, last_row;
  logic [IDX_BITS-1:0]   bit_idx;

  assign last_col = col_q == COL_LAST;
  assign last_row = row_q == ROW_LAST;
  assign capture  = state_q == IDLE && bus.ReqIn && armed_q;
  assign xfer     = state_q == STREAM && bus.PixReady;
  // Raster-order successor of the current pixel; only used when not at the last pixel
  assign col_n    = last_col ? '0 : col_q + COL_BITS'(1);
  assign row_n    = last_col ? row_q + ROW_BITS'(1) : row_q;
  assign bit_idx  = IDX_BITS'((int'(row_n)*MATRIX_N + int'(col_n))*IMAGE_BITS);

  // State, frame buffer and registered pixel outputs
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
      armed_q <= 1'b1;
      buf_q   <= '0;
      row_q   <= '0;
      col_q   <= '0;
      pix_q   <= '0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      buf_q   <= buf_d;
      row_q   <= row_d;
      col_q   <= col_d;
      pix_q   <= pix_d;
      ack_q   <= ack_d;
    end
  end

  // Capture on an armed request, then advance one pixel per accepted beat; the next pixel is
  // pre-fetched from the buffer so PixOut is a register with no path from PixReady
  always_comb begin
    state_d = state_q;
    armed_d = bus.ReqIn ? armed_q : 1'b1;
    buf_d   = buf_q;
    row_d   = row_q;
    col_d   = col_q;
    pix_d   = pix_q;
    ack_d   = 1'b0;
    if (capture) begin
      state_d = STREAM;
      armed_d = 1'b0;
      buf_d   = bus.MatIn;
      row_d   = '0;
      col_d   = '0;
      pix_d   = bus.MatIn[IMAGE_BITS-1:0];
      ack_d   = 1'b1;
    end else if (xfer) begin
      if (last_col && last_row) begin
        state_d = IDLE;
      end else begin
        row_d = row_n;
        col_d = col_n;
        pix_d = buf_q[bit_idx +: IMAGE_BITS];
      end
    end
  end

  assign bus.AckIn      = ack_q;
  assign bus.PixValid   = state_q == STREAM;
  assign bus.Busy       = state_q == STREAM;
  assign bus.PixOut     = pix_q;
  assign bus.PixRow     = row_q;
  assign bus.PixCol     = col_q;
  assign bus.FrameStart = state_q == STREAM && row_q == '0 && col_q == '0;
  assign bus.FrameEnd   = state_q == STREAM && last_row && last_col;
endmodule

// File: tb/tb_frame_serializer.sv
// tb_frame_serializer: directed frames checked against a pixel scoreboard
module tb_frame_serializer;
  localparam int IB = 8, N = 4, M = 3, CB = 2, RB = 2, FW = IB*N*M;

  typedef struct {
    logic [7:0] v;
    logic [1:0] r;
    logic [1:0] c;
    logic       fs;
    logic       fe;
  } pix_t;

  logic Clk = 1'b0;
  logic Reset = 1'b0;
  pix_t q[$];
  int n = 0;
  int nf = 0;
  int acks = 0;

  always #5 Clk = ~Clk;

  frame_serializer_if #(.IMAGE_BITS(IB), .MATRIX_N(N), .MATRIX_M(M), .COL_BITS(CB), .ROW_BITS(RB), .FLAT_WIDE(FW)) bus ();

  frame_serializer #(.IMAGE_BITS(IB), .MATRIX_N(N), .MATRIX_M(M), .COL_BITS(CB), .ROW_BITS(RB), .FLAT_WIDE(FW)) dut (
    .Clk(Clk),
    .Reset(Reset),
    .bus(bus)
  );

  function automatic logic [FW-1:0] mk(input int off);
    logic [FW-1:0] m;
    m = '0;
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++)
        m[(i*N+j)*IB +: IB] = 8'(16*i + j + off);
    return m;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n++;
    assert (obs === exp) else begin
      nf++;
      $error("FAIL %s got %0h need %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int off);
    for (int i = 0; i < M; i++)
      for (int j = 0; j < N; j++)
        q.push_back('{v: 8'(16*i + j + off), r: 2'(i), c: 2'(j), fs: (i == 0 && j == 0), fe: (i == M-1 && j == N-1)});
  endtask

  task automatic cyc(input logic rdy);
    @(negedge Clk);
    bus.PixReady = rdy;
    if (bus.AckIn === 1'b1) acks++;
    chk("busy", 32'(bus.Busy), 32'(bus.PixValid));
    if (q.size() == 0) chk("no_extra_valid", 32'(bus.PixValid), 0);
    else if (bus.PixValid === 1'b1) begin
      chk("pix_val", 32'(bus.PixOut), 32'(q[0].v));
      chk("pix_row", 32'(bus.PixRow), 32'(q[0].r));
      chk("pix_col", 32'(bus.PixCol), 32'(q[0].c));
      chk("frame_start", 32'(bus.FrameStart), 32'(q[0].fs));
      chk("frame_end", 32'(bus.FrameEnd), 32'(q[0].fe));
      if (rdy) void'(q.pop_front());
    end
  endtask

  task automatic stream(input bit toggle, input int chg_at);
    for (int k = 0; k < 80 && q.size() > 0; k++) begin
      if (k == chg_at) bus.MatIn = mk(8'h80);
      cyc(toggle ? (k % 4 == 0 || k % 4 == 3) : 1'b1);
    end
    chk("frame_done", q.size(), 0);
    cyc(1'b1);
    chk("valid_drop", 32'(bus.PixValid), 0);
  endtask

  initial begin
    bus.ReqIn = 1'b0;
    bus.MatIn = mk(0);
    bus.PixReady = 1'b0;
    repeat (2) @(negedge Clk);
    chk("rst_valid", 32'(bus.PixValid), 0);
    chk("rst_ack", 32'(bus.AckIn), 0);
    chk("rst_pixout", 32'(bus.PixOut), 0);
    Reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cyc(1'b1);
      chk("idle_ack", 32'(bus.AckIn), 0);
      chk("idle_valid", 32'(bus.PixValid), 0);
      chk("idle_busy", 32'(bus.Busy), 0);
      chk("idle_pixout", 32'(bus.PixOut), 0);
    end
    bus.ReqIn = 1'b1;
    push(0);
    stream(1'b0, 5);
    repeat (3) cyc(1'b1);
    chk("pixout_keeps_last", 32'(bus.PixOut), 32'h23);
    chk("acks_a", acks, 1);
    bus.ReqIn = 1'b0;
    cyc(1'b1);
    bus.ReqIn = 1'b1;
    bus.MatIn = mk(1);
    push(1);
    stream(1'b1, 9);
    chk("acks_b", acks, 2);
    bus.ReqIn = 1'b0;
    cyc(1'b1);
    bus.ReqIn = 1'b1;
    bus.MatIn = mk(0);
    push(0);
    for (int k = 0; k < 40 && q.size() > 0 && q[0].v !== 8'h12; k++) cyc(1'b1);
    cyc(1'b0);
    chk("at_12", 32'(bus.PixOut), 32'h12);
    Reset = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.PixValid), 0);
    chk("mid_rst_pixout", 32'(bus.PixOut), 0);
    chk("mid_rst_row", 32'(bus.PixRow), 0);
    chk("mid_rst_col", 32'(bus.PixCol), 0);
    chk("mid_rst_busy", 32'(bus.Busy), 0);
    chk("mid_rst_fs", 32'(bus.FrameStart), 0);
    chk("mid_rst_fe", 32'(bus.FrameEnd), 0);
    chk("mid_rst_ack", 32'(bus.AckIn), 0);
    q.delete();
    repeat (2) cyc(1'b1);
    Reset = 1'b1;
    push(0);
    stream(1'b0, -1);
    chk("acks_total", acks, 4);
    $display("End of test - %0d assertions evaluated, %0d failures", n, nf);
    $finish;
  end
endmodule

// File: doc/frame_serializer.md
Name: frame_serializer

Overview:
- Downstream consumer of the Mixer stage's Req/Ack interface.
- Captures one flattened image matrix (same bit layout as the Mixer's MixedMat) when upstream requests, then streams it out one pixel per accepted beat, row-major, on a valid/ready pixel port.
- Feeds display and debug readout of the Hough-transform overlay result.

Parameters:
- IMAGE_BITS, 8, bits per pixel
- MATRIX_N, 120, pixels across (columns)
- MATRIX_M, 120, pixels down (rows)
- COL_BITS, 7, width of column index; must satisfy 2^COL_BITS >= MATRIX_N
- ROW_BITS, 7, width of row index; must satisfy 2^ROW_BITS >= MATRIX_M
- FLAT_WIDE, IMAGE_BITS*MATRIX_N*MATRIX_M, flattened matrix width

Ports:
- Clk  input  1  clock, rising edge
- Reset  input  1  asynchronous, active-low reset
- ReqIn  input  1  request from the last stage; MatIn is valid while high
- MatIn  input  FLAT_WIDE  flattened image matrix
- AckIn  output  1  acknowledge to the last stage; one-cycle pulse on capture
- PixOut  output  IMAGE_BITS  current pixel value
- PixValid  output  1  PixOut/PixRow/PixCol are valid
- PixReady  input  1  sink accepts the pixel this cycle
- PixRow  output  ROW_BITS  row index i of PixOut
- PixCol  output  COL_BITS  column index j of PixOut
- FrameStart  output  1  high while pixel (0,0) is presented
- FrameEnd  output  1  high while pixel (M-1,N-1) is presented
- Busy  output  1  high in STREAM state

Behaviour:
- Pixel layout: pixel (i,j) = MatIn[((i*MATRIX_N)+j)*IMAGE_BITS +: IMAGE_BITS]. i is the row (0..M-1), j is the column (0..N-1).
- Reset (Reset low, async): state=IDLE; frame buffer, PixOut, PixRow and PixCol = 0; AckIn, PixValid, FrameStart, FrameEnd and Busy = 0; Armed=1.
- Reset mid-frame: the frame is discarded with no further pixels and no FrameEnd.
- Armed flag: cleared on capture, set on any cycle where ReqIn=0. This prevents re-capturing a held-high ReqIn.
- IDLE:
  - PixValid=0, Busy=0.
  - On a clock edge with ReqIn=1 and Armed=1: latch MatIn into the frame buffer, row=col=0, go to STREAM.
  - After that edge: AckIn=1 for exactly one cycle, PixValid=1, PixOut=pixel(0,0), FrameStart=1.
  - Capture-to-first-pixel latency is 1 cycle.
- STREAM:
  - PixValid=1, Busy=1. ReqIn is ignored, and AckIn stays 0 after its pulse.
  - Transfer occurs on an edge where PixValid and PixReady are both 1.
  - Without a transfer, PixOut, PixRow, PixCol, FrameStart and FrameEnd hold stable.
  - On a transfer with col<N-1: col+1.
  - On a transfer with col=N-1 and row<M-1: col=0, row+1.
  - On a transfer at (M-1,N-1): go to IDLE; PixValid, FrameEnd and Busy drop after that edge. PixOut keeps its last value.
  - All pixel outputs are registered, with no combinational path from PixReady to any output.
- Back-to-back frames:
  - Capture is possible on the edge after returning to IDLE, provided ReqIn has been low for at least one cycle since the previous AckIn.
  - Minimum frame period is M*N+1 cycles with PixReady held high.
- Degenerate sizes:
  - N=1: col stays 0 and row advances every transfer.
  - M=N=1: FrameStart and FrameEnd are both high on the single pixel.
- The frame buffer is written only on capture, so MatIn may change freely after the AckIn pulse.

Test Plan (bench params IMAGE_BITS=8, N=4, M=3, pixel(i,j)=16*i+j):
- Reset then idle, ReqIn=0 for 10 cycles -> AckIn, PixValid and Busy stay 0; PixOut=0.
- ReqIn=1 and PixReady=1 held -> AckIn pulses for 1 cycle; 12 pixels appear in order 0x00,0x01,0x02,0x03,0x10,...,0x23 on consecutive cycles; FrameStart only on 0x00, FrameEnd only on 0x23; PixValid falls after 0x23.
- PixReady toggling 1,0,0,1 -> each pixel is held across the stall cycles; the sequence is complete with no duplicates or drops; indices match values (PixRow=i, PixCol=j).
- ReqIn held high through the end of the frame -> no second capture; after ReqIn goes low for 1 cycle then high again, the second frame (values +1) streams correctly. MatIn changed mid-stream does not alter the output.
- Reset asserted at pixel 0x12 -> all outputs go to 0 immediately; after reset release with ReqIn=1, a new frame starts at 0x00.
